// File: rtl/vga_grid_pkg.sv
// Shared constants, types and the cell-address helper for the VGA color-cell grid.
package vga_grid_pkg;

    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 6;
    localparam int CELL_W    = 80;
    localparam int CELL_H    = 80;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;
    localparam int ADDR_W    = $clog2(NUM_CELLS);

    typedef logic [2:0] color_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } arb_state_t;

    // Row-major cell index; only meaningful for in-range row/col.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] row, input logic [9:0] col);
        return ADDR_W'(row * 10'(GRID_COLS) + col);
    endfunction

endpackage

// File: rtl/vga_cell_locator.sv
// Registers the RAM address for the next cycle: the cell under the beam, or an
// arbiter-supplied write address, plus the active-pixel flag that rides along.
module vga_cell_locator
    import vga_grid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        counterH,
    input  logic [9:0]        counterV,
    input  logic              vga_blank,
    input  logic              ovr_en,
    input  logic [ADDR_W-1:0] ovr_addr,
    output logic [ADDR_W-1:0] addr_p0,
    output logic              vld_p0
);

    localparam logic [9:0] CELL_W10   = 10'(CELL_W);
    localparam logic [9:0] CELL_H10   = 10'(CELL_H);
    localparam logic [9:0] H_ACTIVE10 = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE10 = 10'(V_ACTIVE);

    logic [9:0] col;
    logic [9:0] row;
    logic       in_active;

    always_comb begin
        col       = counterH / CELL_W10;
        row       = counterV / CELL_H10;
        in_active = vga_blank && (counterH < H_ACTIVE10) && (counterV < V_ACTIVE10);
    end

    // stage t -> t+1: address presented to the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            addr_p0 <= ovr_en ? ovr_addr : cell_addr(row, col);
            vld_p0  <= in_active && !ovr_en;
        end
    end

endmodule

// File: rtl/vga_grid_arbiter.sv
// Shares the single-port color-cell RAM between the pixel read pipeline and
// game-logic writes/clears; writes only ever use cycles sampled as blanking.
module vga_grid_arbiter
    import vga_grid_pkg::*;
(
    input  logic              vgaclk,
    input  logic              rst,
    input  logic [9:0]        counterH,
    input  logic [9:0]        counterV,
    input  logic              vga_blank,
    input  logic              wr_req,
    input  logic [2:0]        wr_col,
    input  logic [2:0]        wr_row,
    input  logic [2:0]        wr_color,
    output logic              wr_ack,
    input  logic              clr_req,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic [2:0]        selector_color,
    output logic              busy
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;
    logic              port_we;
    logic [ADDR_W-1:0] port_addr;
    color_sel_t        port_wdata;
    logic              ack_nxt;
    logic              done_nxt;
    logic              wr_in_range;
    logic              vld_p0;
    logic              vld_p1;

    assign wr_in_range = ({1'b0, wr_col} < 4'(GRID_COLS)) && ({1'b0, wr_row} < 4'(GRID_ROWS));

    vga_cell_locator u_locator (
        .clk       (vgaclk),
        .rst       (rst),
        .counterH  (counterH),
        .counterV  (counterV),
        .vga_blank (vga_blank),
        .ovr_en    (port_we),
        .ovr_addr  (port_addr),
        .addr_p0   (mem_addr),
        .vld_p0    (vld_p0)
    );

    // Port decisions are made on the sampled vga_blank and appear one cycle later.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        port_we     = 1'b0;
        port_addr   = '0;
        port_wdata  = '0;
        ack_nxt     = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!vga_blank) begin
                    if (clr_req) begin
                        state_nxt   = CLEAR;
                        clr_idx_nxt = '0;
                    end else if (wr_req) begin
                        state_nxt = WRITE;
                        ack_nxt   = 1'b1;
                        if (wr_in_range) begin
                            port_we    = 1'b1;
                            port_addr  = cell_addr(10'(wr_row), 10'(wr_col));
                            port_wdata = wr_color;
                        end
                    end
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            CLEAR: begin
                // clr_idx reaching NUM_CELLS means the last cell was written last cycle
                if (clr_idx == ADDR_W'(NUM_CELLS)) begin
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                    clr_idx_nxt = '0;
                end else if (!vga_blank) begin
                    port_we     = 1'b1;
                    port_addr   = clr_idx;
                    clr_idx_nxt = clr_idx + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // stage t+1 -> t+3: read data returns at t+2 and is gated by the travelling flag
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            clr_idx        <= '0;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
            wr_ack         <= 1'b0;
            clr_done       <= 1'b0;
            busy           <= 1'b0;
            vld_p1         <= 1'b0;
            selector_color <= '0;
        end else begin
            state          <= state_nxt;
            clr_idx        <= clr_idx_nxt;
            mem_we         <= port_we;
            mem_wdata      <= port_wdata;
            wr_ack         <= ack_nxt;
            clr_done       <= done_nxt;
            busy           <= (state_nxt != IDLE);
            vld_p1         <= vld_p0;
            selector_color <= vld_p1 ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_grid_arbiter.sv
// Directed bench for vga_grid_arbiter with a behavioural 1-cycle-latency cell RAM.
module tb_vga_grid_arbiter;

    logic       vgaclk;
    logic       rst;
    logic [9:0] counterH;
    logic [9:0] counterV;
    logic       vga_blank;
    logic       wr_req;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic [2:0] wr_color;
    logic       wr_ack;
    logic       clr_req;
    logic       clr_done;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;
    logic [2:0] selector_color;
    logic       busy;

    logic       pre_we;
    logic [5:0] pre_addr;
    logic [2:0] pre_data;
    logic [2:0] ram [0:63];

    int n_checks = 0;
    int n_errors = 0;

    vga_grid_arbiter dut (
        .vgaclk         (vgaclk),
        .rst            (rst),
        .counterH       (counterH),
        .counterV       (counterV),
        .vga_blank      (vga_blank),
        .wr_req         (wr_req),
        .wr_col         (wr_col),
        .wr_row         (wr_row),
        .wr_color       (wr_color),
        .wr_ack         (wr_ack),
        .clr_req        (clr_req),
        .clr_done       (clr_done),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .selector_color (selector_color),
        .busy           (busy)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (pre_we) ram[pre_addr] <= pre_data;
            else if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_pix(input int h, input int v, input logic b);
        counterH  = 10'(h);
        counterV  = 10'(v);
        vga_blank = b;
    endtask

    task automatic load(input int a, input int d);
        pre_addr = 6'(a);
        pre_data = 3'(d);
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; counterH = '0; counterV = '0; vga_blank = 1'b0;
        wr_req = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0; clr_req = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        ticks(2);
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_done", clr_done, 0);
        check("rst_sel", selector_color, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        load(17, 5);
        load(47, 6);

        // video read path latency and range gating
        set_pix(85, 170, 1'b0); ticks(3);
        set_pix(85, 170, 1'b1); tick();
        check("vid_addr", mem_addr, 17);
        check("vid_we", mem_we, 0);
        tick();
        check("vid_lat2", selector_color, 0);
        tick();
        check("vid_sel", selector_color, 5);
        set_pix(700, 170, 1'b1); ticks(2);
        check("h_oor_lat2", selector_color, 5);
        tick();
        check("h_oor_sel", selector_color, 0);
        set_pix(639, 479, 1'b1); tick();
        check("corner_addr", mem_addr, 47);
        ticks(2);
        check("corner_sel", selector_color, 6);
        set_pix(639, 480, 1'b1); ticks(3);
        check("v_oor_sel", selector_color, 0);
        set_pix(85, 170, 1'b1); ticks(3);
        check("vid_hold", selector_color, 5);
        set_pix(85, 170, 1'b0); ticks(3);
        check("blank_sel", selector_color, 0);

        // write deferred until blanking
        set_pix(85, 170, 1'b1);
        wr_col = 3'd3; wr_row = 3'd2; wr_color = 3'd4; wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("defer_we", mem_we, 0);
            check("defer_ack", wr_ack, 0);
        end
        vga_blank = 1'b0;
        tick();
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 19);
        check("wr_wdata", mem_wdata, 4);
        check("wr_ack", wr_ack, 1);
        check("wr_busy", busy, 1);
        wr_req = 1'b0;
        tick();
        check("wr_ack_pulse", wr_ack, 0);
        check("wr_we_end", mem_we, 0);
        check("wr_busy_end", busy, 0);
        set_pix(240, 160, 1'b1); ticks(3);
        check("wr_readback", selector_color, 4);

        // out-of-range write is acked but not performed
        vga_blank = 1'b0;
        wr_col = 3'd6; wr_row = 3'd6; wr_color = 3'd7; wr_req = 1'b1;
        tick();
        check("oor_ack", wr_ack, 1);
        check("oor_we", mem_we, 0);
        wr_req = 1'b0;
        tick();
        check("oor_ack_end", wr_ack, 0);

        // clear has priority over a simultaneous write
        vga_blank = 1'b0; clr_req = 1'b1;
        wr_req = 1'b1; wr_col = 3'd1; wr_row = 3'd0; wr_color = 3'd2;
        tick();
        check("clr_busy", busy, 1);
        check("clr_first_we", mem_we, 0);
        clr_req = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            check("clr_we", mem_we, 1);
            check("clr_addr", mem_addr, i);
            check("clr_wdata", mem_wdata, 0);
        end
        tick();
        check("clr_done", clr_done, 1);
        check("clr_no_ack", wr_ack, 0);
        check("clr_we_end", mem_we, 0);
        tick();
        check("clr_done_pulse", clr_done, 0);
        check("post_clr_ack", wr_ack, 1);
        check("post_clr_we", mem_we, 1);
        check("post_clr_addr", mem_addr, 1);
        check("post_clr_wdata", mem_wdata, 2);
        wr_req = 1'b0;
        tick();
        check("post_clr_busy", busy, 0);
        set_pix(85, 170, 1'b1); ticks(3);
        check("clr_readback", selector_color, 0);
        set_pix(80, 0, 1'b1); ticks(3);
        check("post_clr_readback", selector_color, 2);

        // clear pauses while video is active
        vga_blank = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            tick();
            check("pause_pre_addr", mem_addr, i);
            check("pause_pre_we", mem_we, 1);
        end
        set_pix(85, 170, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pause_we", mem_we, 0);
            check("pause_addr", mem_addr, 17);
            check("pause_busy", busy, 1);
        end
        vga_blank = 1'b0;
        for (int i = 21; i < 48; i++) begin
            tick();
            check("resume_addr", mem_addr, i);
            check("resume_we", mem_we, 1);
        end
        tick();
        check("pause_done", clr_done, 1);
        tick();
        check("pause_done_end", clr_done, 0);
        check("pause_busy_end", busy, 0);

        // reset in the middle of a clear aborts it
        vga_blank = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        ticks(2);
        check("pre_rst_we", mem_we, 1);
        check("pre_rst_addr", mem_addr, 1);
        rst = 1'b1;
        #1;
        check("async_rst_we", mem_we, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sel", selector_color, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (clr_done || busy || mem_we) seen = 1;
        end
        check("rst_abort", seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
